// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter giving a CPU port and a debug port
// one-at-a-time access to a register file through a three-phase memory sequence.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset,
    input  logic                  a_req,
    input  logic                  a_rw,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic                  b_req,
    input  logic                  b_rw,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  a_done,
    output logic                  a_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  b_done,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [1:0]            control_state,
    output logic                  reg_file_en,
    output logic                  reg_file_rw,
    output logic [ADDR_WIDTH-1:0] reg_sel,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic [DATA_WIDTH-1:0] reg_rd_data
);
    typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;
    state_t                state_q, state_d;
    logic                  gnt_b_q, gnt_b_d;
    logic                  err_q, err_d;
    logic                  rw_q, rw_d;
    logic [ADDR_WIDTH-1:0] sel_q, sel_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;
    logic                  pick_b, req_ok, resp_a, resp_b;
    logic [ADDR_WIDTH-1:0] req_addr;

    // gnt_b_q doubles as the last-grant pointer: the current grant is the last one
    always_comb begin
        pick_b   = b_req && (!a_req || !gnt_b_q);
        req_addr = pick_b ? b_addr : a_addr;
        req_ok   = 32'(req_addr) < DEPTH;
        state_d  = state_q;
        gnt_b_d  = gnt_b_q;
        err_d    = err_q;
        rw_d     = rw_q;
        sel_d    = sel_q;
        wd_d     = wd_q;
        case (state_q)
            IDLE: if (a_req || b_req) begin
                gnt_b_d = pick_b;
                err_d   = !req_ok;
                state_d = req_ok ? EXEC1 : RESP;
                if (req_ok) begin
                    rw_d  = pick_b ? b_rw : a_rw;
                    sel_d = req_addr;
                    wd_d  = pick_b ? b_wdata : a_wdata;
                end
            end
            EXEC1:   state_d = EXEC2;
            EXEC2:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset) begin
            state_q <= IDLE;
            gnt_b_q <= 1'b1;
            err_q   <= 1'b0;
            rw_q    <= 1'b0;
            sel_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_b_q <= gnt_b_d;
            err_q   <= err_d;
            rw_q    <= rw_d;
            sel_q   <= sel_d;
            wd_q    <= wd_d;
        end
    end

    assign resp_a        = state_q == RESP && !gnt_b_q;
    assign resp_b        = state_q == RESP && gnt_b_q;
    assign a_done        = resp_a;
    assign b_done        = resp_b;
    assign a_err         = resp_a && err_q;
    assign b_err         = resp_b && err_q;
    assign a_rdata       = (resp_a && !err_q && !rw_q) ? reg_rd_data : '0;
    assign b_rdata       = (resp_b && !err_q && !rw_q) ? reg_rd_data : '0;
    assign control_state = state_q == RESP ? 2'd0 : state_q;
    assign reg_file_en   = state_q == EXEC1 || state_q == EXEC2;
    assign reg_file_rw   = rw_q;
    assign reg_sel       = sel_q;
    assign reg_wr_data   = wd_q;
endmodule
